// File: rtl/control_unit.sv
// Multi-cycle sequencer for the Core101 datapath: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath enables.
module control_unit #(
  parameter int RETIRE_WIDTH = 32
) (
  input  logic                    control_unit_clock_in,
  input  logic                    control_unit_reset_in,
  input  logic [6:0]              control_unit_opcode_in,
  input  logic                    control_unit_imem_ready_in,
  input  logic                    control_unit_dmem_ready_in,
  input  logic                    control_unit_branch_taken_in,
  output logic                    control_unit_imem_req_out,
  output logic                    control_unit_ir_set_out,
  output logic                    control_unit_pc_set_out,
  output logic [1:0]              control_unit_pc_mux_sel_out,
  output logic                    control_unit_imm_mux_sel_out,
  output logic                    control_unit_gpr_set_rd_out,
  output logic                    control_unit_dmem_read_out,
  output logic                    control_unit_dmem_write_out,
  output logic                    control_unit_illegal_out,
  output logic [2:0]              control_unit_state_out,
  output logic [RETIRE_WIDTH-1:0] control_unit_retired_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } cls_t;

  state_t                  state;
  cls_t                    cls;
  logic                    taken;
  logic                    imem_req;
  logic                    pc_set;
  logic [1:0]              pc_mux_sel;
  logic                    imm_mux_sel;
  logic                    gpr_set_rd;
  logic                    dmem_read;
  logic                    dmem_write;
  logic                    illegal;
  logic [RETIRE_WIDTH-1:0] retired;
  cls_t                    dec_cls;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0000011:             classify = CL_LOAD;
      7'b0100011:             classify = CL_STORE;
      7'b0010011, 7'b0011011: classify = CL_OPIMM;
      7'b0110011, 7'b0111011: classify = CL_OP;
      7'b1100011:             classify = CL_BRANCH;
      7'b1101111:             classify = CL_JAL;
      7'b1100111:             classify = CL_JALR;
      7'b0110111:             classify = CL_LUI;
      7'b0010111:             classify = CL_AUIPC;
      default:                classify = CL_NONE;
    endcase
  endfunction

  function automatic logic uses_imm(input cls_t c);
    uses_imm = (c == CL_LOAD) || (c == CL_STORE) || (c == CL_OPIMM) ||
               (c == CL_JALR) || (c == CL_LUI)   || (c == CL_AUIPC);
  endfunction

  function automatic logic [1:0] wb_pc_sel(input cls_t c, input logic tk);
    case (c)
      CL_JAL:    wb_pc_sel = 2'd1;
      CL_BRANCH: wb_pc_sel = tk ? 2'd1 : 2'd0;
      CL_JALR:   wb_pc_sel = 2'd2;
      default:   wb_pc_sel = 2'd0;
    endcase
  endfunction

  function automatic logic writes_rd(input cls_t c);
    writes_rd = (c != CL_STORE) && (c != CL_BRANCH);
  endfunction

  assign dec_cls = classify(control_unit_opcode_in);

  // Outputs are registered: each transition loads the enables for the state being entered.
  always_ff @(posedge control_unit_clock_in) begin
    if (!control_unit_reset_in) begin
      state       <= IDLE;
      cls         <= CL_NONE;
      taken       <= 1'b0;
      imem_req    <= 1'b0;
      pc_set      <= 1'b0;
      pc_mux_sel  <= 2'd0;
      imm_mux_sel <= 1'b0;
      gpr_set_rd  <= 1'b0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      imem_req   <= 1'b0;
      pc_set     <= 1'b0;
      pc_mux_sel <= 2'd0;
      gpr_set_rd <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      case (state)
        IDLE: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          imm_mux_sel <= 1'b0;
        end
        FETCH: begin
          imm_mux_sel <= 1'b0;
          if (control_unit_imem_ready_in) state <= DECODE;
          else                            imem_req <= 1'b1;
        end
        DECODE: begin
          if (dec_cls == CL_NONE) begin
            illegal     <= 1'b1;
            imm_mux_sel <= 1'b0;
            state       <= HALT;
          end else begin
            cls         <= dec_cls;
            imm_mux_sel <= uses_imm(dec_cls);
            state       <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (cls == CL_BRANCH) taken <= control_unit_branch_taken_in;
          if (cls == CL_LOAD || cls == CL_STORE) begin
            state      <= MEMORY;
            dmem_read  <= (cls == CL_LOAD);
            dmem_write <= (cls == CL_STORE);
          end else begin
            // The branch flag is being latched on this same edge, so use the live input.
            state      <= WRITEBACK;
            pc_set     <= 1'b1;
            pc_mux_sel <= wb_pc_sel(cls, control_unit_branch_taken_in);
            gpr_set_rd <= writes_rd(cls);
          end
        end
        MEMORY: begin
          if (control_unit_dmem_ready_in) begin
            state      <= WRITEBACK;
            pc_set     <= 1'b1;
            pc_mux_sel <= wb_pc_sel(cls, taken);
            gpr_set_rd <= writes_rd(cls);
          end else begin
            dmem_read  <= (cls == CL_LOAD);
            dmem_write <= (cls == CL_STORE);
          end
        end
        WRITEBACK: begin
          retired     <= retired + RETIRE_WIDTH'(1);
          imem_req    <= 1'b1;
          imm_mux_sel <= 1'b0;
          state       <= FETCH;
        end
        HALT: begin
          imm_mux_sel <= 1'b0;
          state       <= HALT;
        end
        default: begin
          imm_mux_sel <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // IR load is the only Mealy output: it follows imem_ready within the FETCH cycle.
  assign control_unit_ir_set_out      = control_unit_reset_in && (state == FETCH) &&
                                        control_unit_imem_ready_in;
  assign control_unit_imem_req_out    = imem_req;
  assign control_unit_pc_set_out      = pc_set;
  assign control_unit_pc_mux_sel_out  = pc_mux_sel;
  assign control_unit_imm_mux_sel_out = imm_mux_sel;
  assign control_unit_gpr_set_rd_out  = gpr_set_rd;
  assign control_unit_dmem_read_out   = dmem_read;
  assign control_unit_dmem_write_out  = dmem_write;
  assign control_unit_illegal_out     = illegal;
  assign control_unit_state_out       = state;
  assign control_unit_retired_out     = retired;

endmodule
